// File: rtl/fx2_fifo_engine.sv
// fx2_fifo_engine: FX2 slave-FIFO protocol engine between EP2 OUT / EP6 IN and the channel fabric.
// Parses {rd, chan} plus 32-bit big-endian length headers, then streams the payload in either direction.
module fx2_fifo_engine #(
    parameter logic [1:0] OUT_EP_ADDR   = 2'b00,
    parameter logic [1:0] IN_EP_ADDR    = 2'b10,
    parameter int         PKT_SIZE_LOG2 = 9
) (
    input  logic       IFCLK,
    input  logic       RST,
    input  logic [7:0] FDI,
    output logic [7:0] FDO,
    output logic       FDS,
    output logic [1:0] ADDR,
    output logic       SLRD,
    output logic       SLWR,
    output logic       SLOE,
    output logic       PKTEND,
    input  logic       FLAGB,
    input  logic       FLAGC,
    output logic [6:0] chan_addr,
    output logic [7:0] h2f_data,
    output logic       h2f_valid,
    input  logic       h2f_ready,
    input  logic [7:0] f2h_data,
    input  logic       f2h_valid,
    output logic       f2h_ready
);
    typedef enum logic [3:0] {
        S_IDLE, S_LEN0, S_LEN1, S_LEN2, S_LEN3, S_WRITE, S_TURN, S_READ, S_PKTEND, S_END
    } state_t;

    state_t                   state_q, state_d;
    logic [31:0]              count_q, count_d;
    logic [6:0]               chan_q, chan_d;
    logic                     rd_q, rd_d;
    logic [PKT_SIZE_LOG2-1:0] sent_q, sent_d;
    logic [1:0]               addr_q, addr_d;
    logic                     act, hdr, is_wr, is_rd, is_pk, pop, wr_xfer, rd_xfer;

    assign act     = ~RST;
    assign hdr     = state_q inside {S_IDLE, S_LEN0, S_LEN1, S_LEN2, S_LEN3};
    assign is_wr   = state_q == S_WRITE;
    assign is_rd   = state_q == S_READ;
    assign is_pk   = state_q == S_PKTEND;
    assign pop     = hdr & FLAGC;
    assign wr_xfer = is_wr & FLAGC & h2f_ready;
    assign rd_xfer = is_rd & FLAGB & f2h_valid;

    // Strobes are gated by RST so a reset aborts the bus in the same cycle.
    assign ADDR      = RST ? OUT_EP_ADDR : addr_q;
    assign SLOE      = ~(act & (hdr | is_wr));
    assign SLRD      = ~(act & (hdr ? FLAGC : wr_xfer));
    assign SLWR      = ~(act & rd_xfer);
    assign PKTEND    = ~(act & is_pk);
    assign FDS       = act & (is_rd | is_pk);
    assign FDO       = (act & is_rd) ? f2h_data : 8'h00;
    assign h2f_data  = FDI;
    assign h2f_valid = act & is_wr & FLAGC;
    assign f2h_ready = act & is_rd & FLAGB;
    assign chan_addr = chan_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        chan_d  = chan_q;
        rd_d    = rd_q;
        sent_d  = sent_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: if (pop) begin
                chan_d  = FDI[6:0];
                rd_d    = FDI[7];
                state_d = S_LEN0;
            end
            S_LEN0: if (pop) begin
                count_d = {count_q[23:0], FDI};
                state_d = S_LEN1;
            end
            S_LEN1: if (pop) begin
                count_d = {count_q[23:0], FDI};
                state_d = S_LEN2;
            end
            S_LEN2: if (pop) begin
                count_d = {count_q[23:0], FDI};
                state_d = S_LEN3;
            end
            S_LEN3: if (pop) begin
                count_d = {count_q[23:0], FDI};
                state_d = (count_d == 32'd0) ? S_IDLE : rd_q ? S_TURN : S_WRITE;
            end
            S_WRITE: if (wr_xfer) begin
                count_d = count_q - 32'd1;
                state_d = (count_q == 32'd1) ? S_IDLE : S_WRITE;
            end
            S_TURN: begin
                addr_d  = IN_EP_ADDR;
                sent_d  = '0;
                state_d = S_READ;
            end
            S_READ: if (rd_xfer) begin
                count_d = count_q - 32'd1;
                sent_d  = sent_q + PKT_SIZE_LOG2'(1);
                // A non-zero residue means the final packet is short and must be committed.
                if (count_q == 32'd1) state_d = (sent_d != '0) ? S_PKTEND : S_END;
            end
            S_PKTEND: state_d = S_END;
            S_END: begin
                addr_d  = OUT_EP_ADDR;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge IFCLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            count_q <= '0;
            chan_q  <= '0;
            rd_q    <= 1'b0;
            sent_q  <= '0;
            addr_q  <= OUT_EP_ADDR;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            chan_q  <= chan_d;
            rd_q    <= rd_d;
            sent_q  <= sent_d;
            addr_q  <= addr_d;
        end
    end
endmodule

// File: tb/tb_fx2_fifo_engine.sv
// tb_fx2_fifo_engine: FX2 FIFO and channel models around fx2_fifo_engine.
// Expected payload bytes are queued when stimulus is loaded and popped as the DUT strobes them.
module tb_fx2_fifo_engine;
    logic       IFCLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] FDI = 8'h00;
    logic [7:0] FDO;
    logic       FDS;
    logic [1:0] ADDR;
    logic       SLRD, SLWR, SLOE, PKTEND;
    logic       FLAGB = 1'b0;
    logic       FLAGC = 1'b0;
    logic [6:0] chan_addr;
    logic [7:0] h2f_data;
    logic       h2f_valid;
    logic       h2f_ready = 1'b0;
    logic [7:0] f2h_data = 8'h00;
    logic       f2h_valid = 1'b0;
    logic       f2h_ready;

    always #5 IFCLK = ~IFCLK;

    fx2_fifo_engine dut (
        .IFCLK(IFCLK), .RST(RST), .FDI(FDI), .FDO(FDO), .FDS(FDS), .ADDR(ADDR),
        .SLRD(SLRD), .SLWR(SLWR), .SLOE(SLOE), .PKTEND(PKTEND), .FLAGB(FLAGB), .FLAGC(FLAGC),
        .chan_addr(chan_addr), .h2f_data(h2f_data), .h2f_valid(h2f_valid), .h2f_ready(h2f_ready),
        .f2h_data(f2h_data), .f2h_valid(f2h_valid), .f2h_ready(f2h_ready)
    );

    logic [7:0] out_q[$], src_q[$], exp_wr[$], exp_rd[$];
    int         n_cmp = 0, n_bad = 0;
    int         hdr_left, cyc, slwr_cnt, pk_cnt, turn_cnt, hv_cnt, h2f_cnt;
    int         flagb_hold, stall_at, off_lo, off_hi;
    bit         tog, stalled;
    logic [6:0] exp_chan;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] cmd, input logic [31:0] len);
        out_q.push_back(cmd);
        for (int i = 3; i >= 0; i--) out_q.push_back(len[8*i +: 8]);
        hdr_left   = 5;
        exp_chan   = cmd[6:0];
        slwr_cnt   = 0;
        pk_cnt     = 0;
        turn_cnt   = 0;
        hv_cnt     = 0;
        h2f_cnt    = 0;
        cyc        = 0;
        stalled    = 1'b0;
        flagb_hold = 0;
    endtask

    task automatic tick();
        bit pop_out, pop_src;
        logic [31:0] e;
        @(negedge IFCLK);
        if (!stalled && stall_at >= 0 && slwr_cnt == stall_at) begin
            flagb_hold = 5;
            stalled    = 1'b1;
        end
        FDI       = out_q.size() > 0 ? out_q[0] : 8'h00;
        FLAGC     = out_q.size() > 0 && !(cyc >= off_lo && cyc < off_hi);
        FLAGB     = flagb_hold == 0;
        h2f_ready = tog ? (cyc % 2 == 0) : 1'b1;
        f2h_valid = src_q.size() > 0;
        f2h_data  = src_q.size() > 0 ? src_q[0] : 8'h00;
        #1;
        check("contention", {31'd0, FDS & ~SLOE}, 32'd0);
        pop_out = !SLRD;
        pop_src = !SLWR;
        if (!SLRD) begin
            check("slrd_flagc", {31'd0, FLAGC}, 32'd1);
            check("slrd_addr", {30'd0, ADDR}, 32'd0);
            if (hdr_left > 0) hdr_left--;
            else begin
                check("slrd_ready", {31'd0, h2f_ready}, 32'd1);
                check("h2f_valid", {31'd0, h2f_valid}, 32'd1);
                check("chan_addr", {25'd0, chan_addr}, {25'd0, exp_chan});
                if (exp_wr.size() > 0) e = {24'd0, exp_wr.pop_front()};
                else e = 32'h1FF;
                check("h2f_data", {24'd0, h2f_data}, e);
                h2f_cnt++;
            end
        end
        if (h2f_valid) hv_cnt++;
        if (!SLWR) begin
            check("slwr_flagb", {31'd0, FLAGB}, 32'd1);
            check("f2h_ready", {31'd0, f2h_ready}, 32'd1);
            check("slwr_addr", {30'd0, ADDR}, 32'd2);
            check("slwr_fds", {31'd0, FDS}, 32'd1);
            if (exp_rd.size() > 0) e = {24'd0, exp_rd.pop_front()};
            else e = 32'h1FF;
            check("fdo", {24'd0, FDO}, e);
            slwr_cnt++;
        end
        if (!PKTEND) begin
            check("pktend_addr", {30'd0, ADDR}, 32'd2);
            check("pktend_fds", {31'd0, FDS}, 32'd1);
            pk_cnt++;
        end
        if (SLOE && !FDS && !RST) turn_cnt++;
        cyc++;
        @(posedge IFCLK);
        if (pop_out) void'(out_q.pop_front());
        if (pop_src) void'(src_q.pop_front());
        if (flagb_hold > 0) flagb_hold--;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_idle(input string tag);
        @(negedge IFCLK);
        #1;
        check({tag, "_addr"}, {30'd0, ADDR}, 32'd0);
        check({tag, "_fds"}, {31'd0, FDS}, 32'd0);
        check({tag, "_out_q"}, out_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_slrd"}, {31'd0, SLRD}, 32'd1);
        check({tag, "_slwr"}, {31'd0, SLWR}, 32'd1);
        check({tag, "_sloe"}, {31'd0, SLOE}, 32'd1);
        check({tag, "_pktend"}, {31'd0, PKTEND}, 32'd1);
        check({tag, "_fds"}, {31'd0, FDS}, 32'd0);
        check({tag, "_addr"}, {30'd0, ADDR}, 32'd0);
        check({tag, "_fdo"}, {24'd0, FDO}, 32'd0);
        check({tag, "_h2f_valid"}, {31'd0, h2f_valid}, 32'd0);
        check({tag, "_f2h_ready"}, {31'd0, f2h_ready}, 32'd0);
        check({tag, "_chan"}, {25'd0, chan_addr}, 32'd0);
    endtask

    initial begin
        stall_at = -1;
        off_lo   = 0;
        off_hi   = 0;
        tog      = 1'b0;
        hdr_left = 0;
        cyc      = 0;
        repeat (3) @(posedge IFCLK);
        @(negedge IFCLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b0;

        // Plain write to channel 5
        send_cmd(8'h05, 32'd3);
        foreach (out_q[i]) if (i >= 0) begin end
        out_q.push_back(8'hA1); out_q.push_back(8'hA2); out_q.push_back(8'hA3);
        exp_wr.push_back(8'hA1); exp_wr.push_back(8'hA2); exp_wr.push_back(8'hA3);
        run(20);
        check("wr_bytes", h2f_cnt, 32'd3);
        check("wr_valid_cycles", hv_cnt, 32'd3);
        check("wr_no_slwr", slwr_cnt, 32'd0);
        check("wr_exp_left", exp_wr.size(), 32'd0);
        check("wr_chan_hold", {25'd0, chan_addr}, 32'd5);
        check_idle("wr_end");

        // Same write with ready toggling and FLAGC dropping mid-payload
        send_cmd(8'h05, 32'd3);
        out_q.push_back(8'hA1); out_q.push_back(8'hA2); out_q.push_back(8'hA3);
        exp_wr.push_back(8'hA1); exp_wr.push_back(8'hA2); exp_wr.push_back(8'hA3);
        tog    = 1'b1;
        off_lo = 8;
        off_hi = 11;
        run(30);
        tog    = 1'b0;
        off_lo = 0;
        off_hi = 0;
        check("bp_bytes", h2f_cnt, 32'd3);
        check("bp_exp_left", exp_wr.size(), 32'd0);
        check("bp_no_slwr", slwr_cnt, 32'd0);
        check_idle("bp_end");

        // Short read of 4 bytes from channel 2
        send_cmd(8'h82, 32'd4);
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(8'h10 + 8'(i));
            exp_rd.push_back(8'h10 + 8'(i));
        end
        run(20);
        check("srd_chan", {25'd0, chan_addr}, 32'd2);
        check("srd_strobes", slwr_cnt, 32'd4);
        check("srd_pktend", pk_cnt, 32'd1);
        check("srd_turn", turn_cnt, 32'd2);
        check("srd_exp_left", exp_rd.size(), 32'd0);
        check_idle("srd_end");

        // Full 512-byte packet with a 5-cycle FLAGB stall at byte 200
        send_cmd(8'h81, 32'd512);
        for (int i = 0; i < 512; i++) begin
            src_q.push_back(8'(i * 7));
            exp_rd.push_back(8'(i * 7));
        end
        stall_at = 200;
        run(600);
        stall_at = -1;
        check("full_stall_seen", {31'd0, stalled}, 32'd1);
        check("full_strobes", slwr_cnt, 32'd512);
        check("full_pktend", pk_cnt, 32'd0);
        check("full_turn", turn_cnt, 32'd2);
        check("full_exp_left", exp_rd.size(), 32'd0);
        check_idle("full_end");

        // Zero-length command is a no-op
        send_cmd(8'h03, 32'd0);
        run(15);
        check("zero_valid", hv_cnt, 32'd0);
        check("zero_slwr", slwr_cnt, 32'd0);
        check("zero_turn", turn_cnt, 32'd0);
        check_idle("zero_end");

        // Reset after 2 of 4 read bytes, then a fresh write
        send_cmd(8'h81, 32'd4);
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(8'h20 + 8'(i));
            exp_rd.push_back(8'h20 + 8'(i));
        end
        for (int i = 0; i < 60 && slwr_cnt < 2; i++) tick();
        check("rst_mid_reached", slwr_cnt, 32'd2);
        RST = 1'b1;
        @(posedge IFCLK);
        @(negedge IFCLK);
        #1;
        check_reset_outputs("rst_mid");
        RST = 1'b0;
        out_q.delete();
        src_q.delete();
        exp_rd.delete();
        exp_wr.delete();
        send_cmd(8'h07, 32'd2);
        out_q.push_back(8'hB1); out_q.push_back(8'hB2);
        exp_wr.push_back(8'hB1); exp_wr.push_back(8'hB2);
        run(15);
        check("post_rst_bytes", h2f_cnt, 32'd2);
        check("post_rst_exp_left", exp_wr.size(), 32'd0);
        check("post_rst_pktend", pk_cnt, 32'd0);
        check("post_rst_chan", {25'd0, chan_addr}, 32'd7);
        check_idle("post_rst_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fx2_fifo_engine.md
Name: fx2_fifo_engine

Overview:
- Protocol engine between the Cypress FX2 slave-FIFO pins (via the board top tristate wrapper) and the FPGA-side channel fabric.
- Parses host command/length headers from EP2 OUT, streams write payloads into channel space, and streams read payloads from channel space back over EP6 IN.
- Issues PKTEND for short final packets.

Parameters:
- OUT_EP_ADDR, 2'b00, FIFOADR value selecting EP2 (host to FPGA).
- IN_EP_ADDR, 2'b10, FIFOADR value selecting EP6 (FPGA to host).
- PKT_SIZE_LOG2, 9, log2 of the EP6 packet size (512 bytes); used for the short-packet test.

Ports:
- IFCLK  input  1  48 MHz FX2 interface clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- FDI  input  8  FIFO data from FX2.
- FDO  output  8  FIFO data to FX2.
- FDS  output  1  drive enable for FDIO (1 = FPGA drives).
- ADDR  output  2  FIFOADR endpoint select.
- SLRD  output  1  active-low FIFO read strobe.
- SLWR  output  1  active-low FIFO write strobe.
- SLOE  output  1  active-low FX2 output enable.
- PKTEND  output  1  active-low packet commit.
- FLAGB  input  1  EP6 not-full, active-high.
- FLAGC  input  1  EP2 not-empty, active-high.
- chan_addr  output  7  current channel.
- h2f_data  output  8  host-to-FPGA byte.
- h2f_valid  output  1  h2f_data is valid.
- h2f_ready  input  1  channel accepts h2f_data.
- f2h_data  input  8  FPGA-to-host byte.
- f2h_valid  input  1  f2h_data is valid.
- f2h_ready  output  1  engine accepts f2h_data.

Behaviour:
- Reset values:
  - state=IDLE; count=0; chan_addr=0.
  - SLRD=SLWR=SLOE=PKTEND=1; FDS=0; ADDR=OUT_EP_ADDR.
  - h2f_valid=0; f2h_ready=0; FDO=0 when FDS=0.
- Reset mid-transfer aborts immediately; no PKTEND is issued.
- Header format: cmd byte {rd, chan[6:0]}, then 32-bit length, big-endian, 4 bytes.
- Header byte pop:
  - In IDLE and LEN0..LEN3: ADDR=OUT_EP_ADDR, SLOE=0, SLRD=~FLAGC.
  - A byte is consumed on each edge where SLRD=0.
- IDLE, on pop:
  - chan_addr<=FDI[6:0]; rd_flag<=FDI[7]; go to LEN0.
  - LEN0..LEN3 shift FDI into count, MSB first.
- After LEN3:
  - count==0: go to IDLE (no-op).
  - rd_flag=0: go to WRITE.
  - rd_flag=1: go to TURN.
- WRITE:
  - ADDR=OUT_EP_ADDR; SLOE=0; h2f_data=FDI; h2f_valid=FLAGC; SLRD=~(FLAGC & h2f_ready). All are combinational.
  - Each transferred byte decrements count.
  - On the edge transferring the byte at count==1, go to IDLE.
- TURN: one cycle with SLOE=1 and FDS=0 (bus turnaround); ADDR<=IN_EP_ADDR; then go to READ.
- READ:
  - FDS=1; FDO=f2h_data.
  - f2h_ready=FLAGB; SLWR=~(FLAGB & f2h_valid).
  - Each transferred byte decrements count.
  - Track sent[PKT_SIZE_LOG2-1:0] as the byte count mod packet size.
- After the last read byte:
  - sent!=0: go to PKTEND state. Hold PKTEND=0 for one cycle with ADDR=IN_EP_ADDR and FDS=1, then go to END.
  - sent==0: go directly to END.
- END: one cycle with FDS=0 and ADDR<=OUT_EP_ADDR; then go to IDLE.
- Handshake rules:
  - No byte is lost or duplicated across stalls. Deasserting FLAGB, FLAGC, h2f_ready or f2h_valid simply holds state.
  - chan_addr stays stable from the cmd byte until return to IDLE.
- Bus contention: FDS=1 and SLOE=0 never occur on the same cycle.
- Width: count is 32-bit unsigned; a 0xFFFFFFFF length is legal and never wraps.

Test Plan:
- Write: host sends 0x05, 00 00 00 03, then A1 A2 A3, with h2f_ready=1.
  - Required: chan_addr=5; h2f sees A1, A2, A3 on 3 cycles; return to IDLE; SLWR stays 1 throughout.
- Write with backpressure: same write with h2f_ready toggling 1/0 every cycle and FLAGC dropping mid-payload.
  - Required: the exact sequence A1, A2, A3; SLRD=0 only when FLAGC & h2f_ready.
- Short read: host sends 0x82, 00 00 00 04; f2h supplies 10 11 12 13.
  - Required: one TURN cycle with FDS=0 and SLOE=1; four SLWR pulses; FDO=10..13; one PKTEND=0 cycle; ADDR back to 00.
- Full-packet read: read of length 512 with FLAGB deasserted for 5 cycles at byte 200.
  - Required: 512 SLWR strobes total; no PKTEND.
- Zero length: 0x03, 00 00 00 00.
  - Required: immediate return to IDLE; no h2f_valid, no SLWR.
- Reset mid-read: RST=1 after 2 of 4 read bytes.
  - Required: next cycle all outputs at reset values, FDS=0, PKTEND=1; a subsequent new command works normally.
